// File: rtl/aes_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_ctrl_pkg
//  Description : Shared constants for the byte-serial AES-128 sequencer:
//                FSM state codes, mux select codes, size defaults and the
//                round-constant xtime helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_ctrl_pkg;

  // Block geometry defaults for AES-128
  localparam int NB_DEFAULT = 16;
  localparam int NR_DEFAULT = 10;

  // Controller states (explicit 2-bit encoding)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  // 4:1 state-path mux selects
  localparam logic [1:0] SEL_LOAD  = 2'b00;  // in ^ key
  localparam logic [1:0] SEL_MIX   = 2'b01;  // sbox -> mixcol -> ^ key
  localparam logic [1:0] SEL_FINAL = 2'b10;  // sbox -> ^ key (last round)
  localparam logic [1:0] SEL_HOLD  = 2'b11;

  // Key-path selects
  localparam logic [1:0] KSEL_EXT  = 2'b00;  // external key byte
  localparam logic [1:0] KSEL_ROT  = 2'b01;  // sbox(rotword) ^ rcon ^ key
  localparam logic [1:0] KSEL_XOR  = 2'b10;  // previous word ^ key
  localparam logic [1:0] KSEL_HOLD = 2'b11;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // GF(2^8) multiply-by-two used to step the round constant
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_rcon_gen.sv
`default_nettype none
// ============================================================================
//  Module      : aes_rcon_gen
//  Description : Round-constant register. Starts at 01 and advances by
//                xtime on request; clr returns it to 01 for the next block.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_rcon_gen
  import aes_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       adv,
  output logic [7:0] rcon
);

  logic [7:0] rcon_q;

  // Round-constant register: clear wins over advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcon_q <= RCON_INIT;
    end else if (clr) begin
      rcon_q <= RCON_INIT;
    end else if (adv) begin
      rcon_q <= xtime(rcon_q);
    end
  end

  assign rcon = rcon_q;

endmodule
`default_nettype wire

// File: rtl/aes_byte_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes_byte_seq_ctrl
//  Description : Sequencer for the 8-bit byte-serial AES-128 datapath.
//                Steps one byte per clock through LOAD, ROUND and OUT,
//                driving mux selects, register enables and the round
//                constant, and handling the byte-stream handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_byte_seq_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR = NR_DEFAULT,
  parameter int NB = NB_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       in_sel,
  output logic [1:0] data_sel,
  output logic [1:0] key_sel,
  output logic       state_en,
  output logic       key_en,
  output logic [7:0] rcon,
  output logic [3:0] byte_idx,
  output logic [3:0] round_idx,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       done
);

  localparam logic [3:0] LAST_BYTE  = 4'(NB - 1);
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  logic [1:0] state;
  logic [3:0] byte_cnt;
  logic [3:0] round_cnt;

  logic last_byte;
  logic final_round;
  logic round_wrap;
  logic out_last_hs;
  logic rcon_adv;

  assign last_byte   = (byte_cnt == LAST_BYTE);
  assign final_round = (round_cnt == LAST_ROUND);
  assign round_wrap  = (state == ST_ROUND) && last_byte;
  assign out_last_hs = (state == ST_OUT) && out_ready && last_byte;
  // The last round's wrap leaves rcon alone; it is cleared when the block ends
  assign rcon_adv    = round_wrap && !final_round;

  // State, byte and round counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      byte_cnt  <= 4'd0;
      round_cnt <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          byte_cnt  <= 4'd0;
          round_cnt <= 4'd0;
          if (start) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (last_byte) begin
              byte_cnt  <= 4'd0;
              round_cnt <= 4'd1;
              state     <= ST_ROUND;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end
        ST_ROUND: begin
          if (last_byte) begin
            byte_cnt <= 4'd0;
            if (final_round) state <= ST_OUT;
            else             round_cnt <= round_cnt + 4'd1;
          end else begin
            byte_cnt <= byte_cnt + 4'd1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            if (last_byte) begin
              byte_cnt  <= 4'd0;
              round_cnt <= 4'd0;
              state     <= ST_IDLE;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  aes_rcon_gen u_rcon (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (out_last_hs),
    .adv   (rcon_adv),
    .rcon  (rcon)
  );

  // Output decode from state; only the enables and done see the handshake inputs
  always_comb begin
    busy      = 1'b0;
    in_ready  = 1'b0;
    in_sel    = 1'b0;
    data_sel  = SEL_HOLD;
    key_sel   = KSEL_HOLD;
    state_en  = 1'b0;
    key_en    = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state)
      ST_LOAD: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        in_sel   = 1'b1;
        data_sel = SEL_LOAD;
        key_sel  = KSEL_EXT;
        state_en = in_valid;
        key_en   = in_valid;
      end
      ST_ROUND: begin
        busy     = 1'b1;
        data_sel = final_round ? SEL_FINAL : SEL_MIX;
        key_sel  = (byte_cnt < 4'd4) ? KSEL_ROT : KSEL_XOR;
        state_en = 1'b1;
        key_en   = 1'b1;
      end
      ST_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        state_en  = out_ready;
        done      = out_last_hs;
      end
      default: ;
    endcase
  end

  assign byte_idx  = byte_cnt;
  assign round_idx = round_cnt;

endmodule
`default_nettype wire

// File: tb/tb_aes_byte_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_byte_seq_ctrl
//  Description : Self-checking bench for aes_byte_seq_ctrl. The reference
//                model tracks a single progress number p (-1 = idle,
//                0..15 load, 16..175 round bytes, 176..191 output bytes)
//                and derives every expected output from it arithmetically.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_byte_seq_ctrl;

  localparam int NB = 16;
  localparam int NR = 10;
  localparam int P_ROUND = NB;
  localparam int P_OUT   = NB + NR * NB;
  localparam int P_LAST  = P_OUT + NB - 1;

  logic       clk, rst_n, start, in_valid, out_ready;
  logic       busy, in_ready, in_sel, state_en, key_en, out_valid, done;
  logic [1:0] data_sel, key_sel;
  logic [7:0] rcon;
  logic [3:0] byte_idx, round_idx;

  aes_byte_seq_ctrl #(.NR(NR), .NB(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .data_sel(data_sel), .key_sel(key_sel), .state_en(state_en),
    .key_en(key_en), .rcon(rcon), .byte_idx(byte_idx),
    .round_idx(round_idx), .out_valid(out_valid), .out_ready(out_ready),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int model_p  = -1;
  logic [7:0] rcon_tab [NR];

  logic [26:0] obs;
  assign obs = {busy, in_ready, in_sel, data_sel, key_sel, state_en, key_en,
                rcon, byte_idx, round_idx, out_valid, done};

  // Expected output vector for progress p with the current handshake inputs
  function automatic logic [26:0] exp_vec(input int p, input logic iv, input logic ordy);
    logic b_e, ir, is, se, ke, ov, dn;
    logic [1:0] ds, ks;
    logic [7:0] rc;
    logic [3:0] bi, ri;
    int q, r, b;
    b_e = 0; ir = 0; is = 0; se = 0; ke = 0; ov = 0; dn = 0;
    ds = 2'b11; ks = 2'b11; rc = 8'h01; bi = 4'd0; ri = 4'd0;
    if (p >= 0 && p < P_ROUND) begin
      b_e = 1; ir = 1; is = 1; ds = 2'b00; ks = 2'b00;
      se = iv; ke = iv; bi = 4'(p);
    end else if (p >= P_ROUND && p < P_OUT) begin
      q = p - P_ROUND; r = q / NB + 1; b = q % NB;
      b_e = 1; se = 1; ke = 1;
      ds = (r < NR) ? 2'b01 : 2'b10;
      ks = (b < 4) ? 2'b01 : 2'b10;
      rc = rcon_tab[r-1]; bi = 4'(b); ri = 4'(r);
    end else if (p >= P_OUT) begin
      b = p - P_OUT;
      b_e = 1; ov = 1; se = ordy; bi = 4'(b);
      dn = ordy && (b == NB - 1);
    end
    return {b_e, ir, is, ds, ks, se, ke, rc, bi, ri, ov, dn};
  endfunction

  // rcon/round_idx while streaming out are not defined by the block's contract
  function automatic logic [26:0] exp_mask(input int p);
    return (p >= P_OUT) ? 27'h7FC03C3 : 27'h7FFFFFF;
  endfunction

  function automatic int next_p(input int p, input logic rn, input logic st,
                                input logic iv, input logic ordy);
    if (!rn)          return -1;
    if (p < 0)        return st ? 0 : -1;
    if (p < P_ROUND)  return iv ? p + 1 : p;
    if (p < P_OUT)    return p + 1;
    if (!ordy)        return p;
    return (p == P_LAST) ? -1 : p + 1;
  endfunction

  // Advance the model with this cycle's inputs, then move past the clock edge
  task automatic tick();
    model_p = next_p(model_p, rst_n, start, in_valid, out_ready);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [26:0] e, m;
    rst_n = 0; start = 0; in_valid = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1; model_p = -1;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      @(negedge clk);
      e = exp_vec(model_p, in_valid, out_ready); m = exp_mask(model_p);
      n_checks++;
      if ((obs & m) !== (e & m)) $display("FAIL reset_idle c=%0d got=%h want=%h", c, obs, e);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [26:0] e, m;
    int done_cyc = -1;
    in_valid = 1; out_ready = 1; start = 1;
    for (int c = 0; c < 200 && done_cyc < 0; c++) begin
      if (c > 0) start = 0;
      @(negedge clk);
      e = exp_vec(model_p, in_valid, out_ready); m = exp_mask(model_p);
      n_checks++;
      if ((obs & m) !== (e & m)) $display("FAIL b2b c=%0d p=%0d got=%h want=%h", c, model_p, obs, e);
      else n_pass++;
      if (done) done_cyc = c;
      tick();
    end
    n_checks++;
    if (done_cyc !== 192) $display("FAIL b2b_latency got=%0d want=192", done_cyc);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [26:0] e, m;
    int done_cyc = -1;
    int iv_hold = 3, or_hold = 5;
    start = 1;
    for (int c = 0; c < 220 && done_cyc < 0; c++) begin
      if (c > 0) start = 0;
      in_valid = 1; out_ready = 1;
      if (model_p == 7 && iv_hold > 0) begin in_valid = 0; iv_hold--; end
      if (model_p == P_OUT + 12 && or_hold > 0) begin out_ready = 0; or_hold--; end
      @(negedge clk);
      e = exp_vec(model_p, in_valid, out_ready); m = exp_mask(model_p);
      n_checks++;
      if ((obs & m) !== (e & m)) $display("FAIL bp c=%0d p=%0d got=%h want=%h", c, model_p, obs, e);
      else n_pass++;
      if (done) done_cyc = c;
      tick();
    end
    in_valid = 1; out_ready = 1;
    n_checks++;
    if (done_cyc !== 200) $display("FAIL bp_latency got=%0d want=200", done_cyc);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [26:0] e, m;
    int blocks = 0, dones = 0, c = 0;
    while (blocks < 3 && c < 3000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      start     = (model_p < 0) ? 1'b1 : ($urandom_range(0, 15) == 0);
      @(negedge clk);
      e = exp_vec(model_p, in_valid, out_ready); m = exp_mask(model_p);
      n_checks++;
      if ((obs & m) !== (e & m)) $display("FAIL rand c=%0d p=%0d got=%h want=%h", c, model_p, obs, e);
      else n_pass++;
      if (done) dones++;
      if (model_p == P_LAST && out_ready) blocks++;
      tick();
      c++;
    end
    start = 0; in_valid = 1; out_ready = 1;
    n_checks++;
    if (blocks != 3 || dones != 3) $display("FAIL rand_blocks got=%0d/%0d want=3/3", blocks, dones);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [26:0] e, m;
    int dones = 0;
    int target = P_ROUND + 4 * NB + 9;  // round 5, byte 9
    start = 1; in_valid = 1; out_ready = 1;
    for (int c = 0; c < 120 && model_p != -2; c++) begin
      if (c > 0) start = (model_p >= P_ROUND) ? 1'($urandom) : 1'b0;
      @(negedge clk);
      e = exp_vec(model_p, in_valid, out_ready); m = exp_mask(model_p);
      n_checks++;
      if ((obs & m) !== (e & m)) $display("FAIL abort_run c=%0d p=%0d got=%h want=%h", c, model_p, obs, e);
      else n_pass++;
      if (model_p == target) begin
        rst_n = 0;
        tick();
        model_p = -2;
      end else begin
        tick();
      end
    end
    n_checks++;
    if (model_p != -2) $display("FAIL abort_reach got=%0d want=%0d", model_p, target);
    else n_pass++;
    model_p = -1; rst_n = 1; start = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      @(negedge clk);
      e = exp_vec(model_p, in_valid, out_ready); m = exp_mask(model_p);
      n_checks++;
      if ((obs & m) !== (e & m)) $display("FAIL abort_idle c=%0d got=%h want=%h", c, obs, e);
      else n_pass++;
      if (done) dones++;
      tick();
    end
    n_checks++;
    if (dones != 0) $display("FAIL abort_done got=%0d want=0", dones);
    else n_pass++;
    in_valid = 1; out_ready = 1;
  endtask

  task automatic test_restart();
    logic [26:0] e, m;
    logic seen_done = 0;
    start = 1; in_valid = 1; out_ready = 1;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      if (c > 0) start = 0;
      @(negedge clk);
      e = exp_vec(model_p, in_valid, out_ready); m = exp_mask(model_p);
      n_checks++;
      if ((obs & m) !== (e & m)) $display("FAIL restart_run c=%0d got=%h want=%h", c, obs, e);
      else n_pass++;
      if (done) seen_done = 1;
      tick();
    end
    n_checks++;
    if (!seen_done) $display("FAIL restart_done got=0 want=1");
    else n_pass++;
    start = 1;   // the cycle right after done
    @(negedge clk);
    tick();
    start = 0;
    @(negedge clk);
    n_checks++;
    if ({in_ready, rcon, round_idx, byte_idx} !== {1'b1, 8'h01, 4'd0, 4'd0})
      $display("FAIL restart_load got=%b/%h/%0d/%0d want=1/01/0/0", in_ready, rcon, round_idx, byte_idx);
    else n_pass++;
    for (int c = 0; c < 220 && model_p >= 0; c++) begin
      if (c > 0) @(negedge clk);
      e = exp_vec(model_p, in_valid, out_ready); m = exp_mask(model_p);
      n_checks++;
      if ((obs & m) !== (e & m)) $display("FAIL restart_blk c=%0d p=%0d got=%h want=%h", c, model_p, obs, e);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (model_p != -1) $display("FAIL restart_end got=%0d want=-1", model_p);
    else n_pass++;
  endtask

  initial begin
    rcon_tab[0] = 8'h01; rcon_tab[1] = 8'h02; rcon_tab[2] = 8'h04; rcon_tab[3] = 8'h08;
    rcon_tab[4] = 8'h10; rcon_tab[5] = 8'h20; rcon_tab[6] = 8'h40; rcon_tab[7] = 8'h80;
    rcon_tab[8] = 8'h1B; rcon_tab[9] = 8'h36;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_abort();
    test_restart();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
